mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data access.
// Rev 1.0 - fixed D-over-I priority with a starvation guard, two cycles per access.
`default_nettype none

module mem_port_arbiter (
  input  logic        clk,
  input  logic        reset,
  // instruction fetch side
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  // data side
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  input  logic [2:0]  d_func3,
  output logic [63:0] d_rdata,
  output logic        d_valid,
  output logic        d_stall,
  // shared memory port
  output logic        mem_en,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [2:0]  mem_func3,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [1:0] STARVE_MAX = 2'd3;
  localparam logic [2:0] FUNC3_WORD = 3'b010;

  state_t     state;
  logic [1:0] starve_cnt;
  logic       d_is_load;
  logic       grant_d;
  logic       grant_i;

  // Grants are only issued from IDLE; reset masks them so the port is quiet
  // while reset is held even though the state already reads IDLE.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (!reset && (state == IDLE)) begin
      if (d_req && (!if_req || (starve_cnt != STARVE_MAX))) begin
        grant_d = 1'b1;
      end else if (if_req) begin
        grant_i = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 64'd0;
    mem_wdata = 64'd0;
    mem_func3 = 3'd0;
    if (grant_d) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_func3 = d_func3;
    end else if (grant_i) begin
      mem_en    = 1'b1;
      mem_addr  = if_addr;
      mem_func3 = FUNC3_WORD;
    end
  end

  assign if_stall = if_req & ~if_valid;
  assign d_stall  = d_req & ~d_valid;

  // Valid pulses are set on the grant edge so they coincide exactly with the
  // BUSY cycle, when mem_rdata is presented by the memory.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= 2'd0;
      d_is_load  <= 1'b0;
      if_valid   <= 1'b0;
      d_valid    <= 1'b0;
      if_rdata   <= 32'd0;
      d_rdata    <= 64'd0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= BUSY_D;
            d_valid   <= 1'b1;
            d_is_load <= ~d_we;
            if (if_req && (starve_cnt != STARVE_MAX)) begin
              starve_cnt <= starve_cnt + 2'd1;
            end
          end else if (grant_i) begin
            state      <= BUSY_I;
            if_valid   <= 1'b1;
            starve_cnt <= 2'd0;
          end
        end
        BUSY_I: begin
          if_rdata <= mem_rdata[31:0];
          state    <= IDLE;
        end
        BUSY_D: begin
          if (d_is_load) begin
            d_rdata <= mem_rdata;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios with hand-computed expectations.
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_stall;
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [2:0]  d_func3;
  logic [63:0] d_rdata;
  logic        d_valid;
  logic        d_stall;
  logic        mem_en;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [2:0]  mem_func3;
  logic [63:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .if_stall  (if_stall),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_func3   (d_func3),
    .d_rdata   (d_rdata),
    .d_valid   (d_valid),
    .d_stall   (d_stall),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_func3 (mem_func3),
    .mem_rdata (mem_rdata)
  );

  // Inputs change at the falling edge (mid-cycle); outputs are sampled 1ns later.
  task automatic test_reset();
    reset = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
    if_addr = 64'h10; d_addr = 64'h20; d_wdata = 64'h55; d_func3 = 3'b011;
    mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b expected 0", mem_en); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
    checks++; if (if_valid !== 1'b0 || d_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got if=%b d=%b expected 0 0", if_valid, d_valid); end
    checks++; if (if_rdata !== 32'd0 || d_rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata: got if=%h d=%h expected 0 0", if_rdata, d_rdata); end
    @(negedge clk);
    reset = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_func3 = 3'b000;
    #1;
    checks++; if (mem_en !== 1'b0 || mem_addr !== 64'd0 || mem_func3 !== 3'd0) begin errors++; $display("FAIL idle_port: got en=%b addr=%h f3=%b expected 0 0 0", mem_en, mem_addr, mem_func3); end
  endtask

  task automatic test_single_fetch();
    @(negedge clk);
    if_req = 1'b1; if_addr = 64'h40; mem_rdata = 64'h0;
    #1;
    checks++; if (mem_en !== 1'b1 || mem_addr !== 64'h40 || mem_we !== 1'b0) begin errors++; $display("FAIL fetch_grant: got en=%b addr=%h we=%b expected 1 40 0", mem_en, mem_addr, mem_we); end
    checks++; if (mem_func3 !== 3'b010 || mem_wdata !== 64'd0) begin errors++; $display("FAIL fetch_func3: got f3=%b wdata=%h expected 010 0", mem_func3, mem_wdata); end
    checks++; if (if_stall !== 1'b1 || if_valid !== 1'b0) begin errors++; $display("FAIL fetch_c0_stall: got stall=%b valid=%b expected 1 0", if_stall, if_valid); end
    @(negedge clk);
    mem_rdata = 64'hAAAA_BBBB_00A0_0093;
    #1;
    checks++; if (if_valid !== 1'b1 || if_stall !== 1'b0) begin errors++; $display("FAIL fetch_c1_valid: got valid=%b stall=%b expected 1 0", if_valid, if_stall); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL fetch_busy_no_grant: got %b expected 0", mem_en); end
    @(negedge clk);
    if_req = 1'b0; mem_rdata = 64'h0;
    #1;
    checks++; if (if_rdata !== 32'h00A0_0093) begin errors++; $display("FAIL fetch_rdata: got %h expected 00a00093", if_rdata); end
    checks++; if (if_valid !== 1'b0 || if_stall !== 1'b0) begin errors++; $display("FAIL fetch_c2: got valid=%b stall=%b expected 0 0", if_valid, if_stall); end
  endtask

  task automatic test_conflict();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h100; d_func3 = 3'b011;
    if_req = 1'b1; if_addr = 64'h44;
    #1;
    checks++; if (mem_en !== 1'b1 || mem_addr !== 64'h100 || mem_func3 !== 3'b011) begin errors++; $display("FAIL conflict_d_first: got en=%b addr=%h f3=%b expected 1 100 011", mem_en, mem_addr, mem_func3); end
    checks++; if (d_stall !== 1'b1 || if_stall !== 1'b1) begin errors++; $display("FAIL conflict_stalls: got d=%b if=%b expected 1 1", d_stall, if_stall); end
    @(negedge clk);
    mem_rdata = 64'h1122_3344_5566_7788;
    #1;
    checks++; if (d_valid !== 1'b1 || if_valid !== 1'b0 || d_stall !== 1'b0) begin errors++; $display("FAIL conflict_d_valid: got dv=%b iv=%b dstall=%b expected 1 0 0", d_valid, if_valid, d_stall); end
    @(negedge clk);
    d_req = 1'b0; mem_rdata = 64'h0;
    #1;
    checks++; if (mem_en !== 1'b1 || mem_addr !== 64'h44 || mem_func3 !== 3'b010) begin errors++; $display("FAIL conflict_i_grant: got en=%b addr=%h f3=%b expected 1 44 010", mem_en, mem_addr, mem_func3); end
    checks++; if (d_rdata !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL conflict_d_rdata: got %h expected 1122334455667788", d_rdata); end
    @(negedge clk);
    mem_rdata = 64'h1234_5678_9ABC_DEF0;
    #1;
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL conflict_i_valid: got %b expected 1", if_valid); end
    @(negedge clk);
    if_req = 1'b0; mem_rdata = 64'h0;
    #1;
    checks++; if (if_rdata !== 32'h9ABC_DEF0) begin errors++; $display("FAIL conflict_if_rdata: got %h expected 9abcdef0", if_rdata); end
  endtask

  // Both requests held: grants every even cycle, pattern D,D,D,I repeating.
  task automatic test_starvation();
    logic        exp_en;
    logic [63:0] exp_addr;
    logic        exp_iv;
    logic        exp_dv;
    int          i_grants = 0;
    mem_rdata = 64'hCAFE_0000_0000_BABE;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 0) begin
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h8000_0000_0000_0301; d_func3 = 3'b000;
        if_req = 1'b1; if_addr = 64'h4000_0000_0000_0082;
      end
      #1;
      exp_en   = (c % 2) == 0;
      exp_addr = !exp_en ? 64'd0 : ((c % 8) == 6) ? 64'h4000_0000_0000_0082 : 64'h8000_0000_0000_0301;
      exp_iv   = (c % 8) == 7;
      exp_dv   = ((c % 2) == 1) && !exp_iv;
      checks++; if (mem_en !== exp_en || mem_addr !== exp_addr) begin errors++; $display("FAIL starve_grant_c%0d: got en=%b addr=%h expected %b %h", c, mem_en, mem_addr, exp_en, exp_addr); end
      checks++; if (if_valid !== exp_iv || d_valid !== exp_dv) begin errors++; $display("FAIL starve_valid_c%0d: got iv=%b dv=%b expected %b %b", c, if_valid, d_valid, exp_iv, exp_dv); end
      if (if_valid === 1'b1) i_grants++;
    end
    checks++; if (i_grants != 2) begin errors++; $display("FAIL starve_i_count: got %0d expected 2", i_grants); end
    @(negedge clk);
    d_req = 1'b0; if_req = 1'b0; mem_rdata = 64'h0;
    #1;
    checks++; if (d_rdata !== 64'hCAFE_0000_0000_BABE || if_rdata !== 32'h0000_BABE) begin errors++; $display("FAIL starve_rdata: got d=%h i=%h expected cafe00000000babe 0000babe", d_rdata, if_rdata); end
  endtask

  task automatic test_store();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h200; d_wdata = 64'hDEAD_BEEF; d_func3 = 3'b011;
    #1;
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 64'h200) begin errors++; $display("FAIL store_grant: got en=%b we=%b addr=%h expected 1 1 200", mem_en, mem_we, mem_addr); end
    checks++; if (mem_wdata !== 64'hDEAD_BEEF || mem_func3 !== 3'b011) begin errors++; $display("FAIL store_data: got wdata=%h f3=%b expected deadbeef 011", mem_wdata, mem_func3); end
    @(negedge clk);
    mem_rdata = 64'h5555_6666_7777_8888;
    #1;
    checks++; if (d_valid !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL store_valid: got dv=%b we=%b expected 1 0", d_valid, mem_we); end
    @(negedge clk);
    d_req = 1'b0; d_we = 1'b0; mem_rdata = 64'h0;
    #1;
    checks++; if (d_rdata !== 64'hCAFE_0000_0000_BABE) begin errors++; $display("FAIL store_rdata_hold: got %h expected cafe00000000babe", d_rdata); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h400; d_func3 = 3'b011;
    #1;
    checks++; if (mem_en !== 1'b1 || mem_addr !== 64'h400) begin errors++; $display("FAIL rmid_grant: got en=%b addr=%h expected 1 400", mem_en, mem_addr); end
    @(negedge clk);
    reset = 1'b1; if_req = 1'b1; mem_rdata = 64'h9999_8888_7777_6666;
    #1;
    checks++; if (d_valid !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid_async: got dv=%b iv=%b expected 0 0", d_valid, if_valid); end
    checks++; if (d_rdata !== 64'd0 || if_rdata !== 32'd0) begin errors++; $display("FAIL rmid_rdata_async: got d=%h i=%h expected 0 0", d_rdata, if_rdata); end
    checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rmid_port: got en=%b we=%b expected 0 0", mem_en, mem_we); end
    @(negedge clk);
    #1;
    checks++; if (d_valid !== 1'b0 || d_rdata !== 64'd0 || mem_en !== 1'b0) begin errors++; $display("FAIL rmid_held: got dv=%b d=%h en=%b expected 0 0 0", d_valid, d_rdata, mem_en); end
    @(negedge clk);
    reset = 1'b0; d_req = 1'b0; if_addr = 64'h48; mem_rdata = 64'h0;
    #1;
    checks++; if (mem_en !== 1'b1 || mem_addr !== 64'h48 || mem_func3 !== 3'b010) begin errors++; $display("FAIL rmid_first_i: got en=%b addr=%h f3=%b expected 1 48 010", mem_en, mem_addr, mem_func3); end
    @(negedge clk);
    mem_rdata = 64'h0000_0000_0000_0013;
    #1;
    checks++; if (if_valid !== 1'b1 || d_valid !== 1'b0) begin errors++; $display("FAIL rmid_i_valid: got iv=%b dv=%b expected 1 0", if_valid, d_valid); end
    @(negedge clk);
    if_req = 1'b0;
    #1;
    checks++; if (if_rdata !== 32'h13 || d_rdata !== 64'd0) begin errors++; $display("FAIL rmid_after: got i=%h d=%h expected 13 0", if_rdata, d_rdata); end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_conflict();
    test_starvation();
    test_store();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
